// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
// The master drives the request; the responder drives ready, the response pulse and busy.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory: one request, response pulse LATENCY cycles later, no response backpressure.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned accesses with resp_err and suppresses their writes.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int ADDR_BITS = $clog2(DEPTH_WORDS);
    localparam int CNT_BITS  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_BITS-1:0]  idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  mis_q, mis_d;
    logic                  err_w;
    logic                  wr_en;

    logic [31:0] mem [DEPTH_WORDS];

`ifdef DMEM_ALIGN_CHECK_EN
    assign err_w = mis_q;
`else
    assign err_w = 1'b0;
    logic unused_mis;
    assign unused_mis = mis_q;
`endif

    // Address bits above the array and the byte offset never select a word.
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[31:ADDR_BITS+2], bus.req_addr[1:0]};

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        we_d           = we_q;
        idx_d          = idx_q;
        wdata_d        = wdata_q;
        mis_d          = mis_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    idx_d   = bus.req_addr[ADDR_BITS+1:2];
                    wdata_d = bus.req_wdata;
                    mis_d   = |bus.req_addr[1:0];
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_BITS'(LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read data comes straight off the array during RESP; no output register.
    assign bus.resp_err   = (state_q == S_RESP) && err_w;
    assign bus.resp_rdata = (state_q == S_RESP && !we_q && !err_w) ? mem[idx_q] : '0;
    assign bus.busy       = (state_q == S_IDLE && bus.req_valid) || (state_q == S_WAIT);
    assign wr_en          = !reset && (state_q == S_RESP) && we_q && !err_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx_q] <= wdata_q;
        end
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that serves the load/store requests issued by the pipelined datapath's memory stage. It accepts one word-wide read or write request at a time and completes it a fixed number of cycles later with a single-cycle response pulse. It also drives a stall indication that the hazard unit uses to freeze the pipeline while an access is outstanding.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words; power of two, ≥ 2. ADDR_BITS = log2(DEPTH_WORDS).
- LATENCY, 2: cycles from acceptance to response; integer ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  read data; valid only while resp_valid is high.
- resp_err  out  1  misalignment error; valid only while resp_valid is high.
- busy  out  1  stall request to the hazard unit.

## Operation
- FSM states: IDLE, WAIT, RESP. Internal latches: we_q, idx_q[ADDR_BITS-1:0], wdata_q, mis_q, and a down-counter cnt.
- IDLE:
  - req_ready = 1.
  - A request is accepted when req_valid && req_ready. On acceptance, capture we, word index req_addr[ADDR_BITS+1:2], wdata, and mis = (req_addr[1:0] != 0).
  - Transition after acceptance: if LATENCY == 1, go to RESP; otherwise go to WAIT with cnt = LATENCY-2.
- WAIT:
  - req_ready = 0.
  - If cnt == 0, go to RESP; else decrement cnt.
- RESP:
  - req_ready = 0, resp_valid = 1. Always returns to IDLE on the next edge.
  - Read: resp_rdata = mem[idx_q].
  - Write: resp_rdata = 0, and mem[idx_q] <= wdata_q on the edge that ends RESP.
- Outside RESP, resp_rdata = 0 and resp_err = 0.
- Address wrap: bits above ADDR_BITS+1 are ignored. For example, address 0x100 with DEPTH_WORDS=64 maps to word 0.
- Only one request is outstanding at a time. Requests are never queued, and req_valid is ignored outside IDLE.
- The response has no backpressure; the requester must consume it in the RESP cycle.
- busy = (state==IDLE && req_valid) || state==WAIT. busy is combinational and deasserts in RESP so the pipeline advances with the response.
- Memory contents are not initialised or cleared by reset.

## Timing
- Request accepted in cycle T → resp_valid high in cycle T+LATENCY only.
- The next acceptance occurs no earlier than T+LATENCY+1. Maximum throughput is one access per LATENCY+1 cycles.
- A write is visible to a read accepted at T+LATENCY+1 or later.
- A read response is combinational from the array in RESP, so no extra register stage is added.
- Reset values: state = IDLE, cnt = 0, all latches = 0. Consequently req_ready = 1 (combinational from IDLE), and resp_valid, resp_rdata, resp_err and busy are 0 when req_valid = 0.
- Reset asserted mid-operation (WAIT or RESP) aborts the access: the FSM goes to IDLE, no response is produced, and a pending write is dropped (the array is not written at that edge).
- req_valid together with reset is ignored; nothing is accepted in that cycle.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A request with mis = 1 is still accepted and timed normally.
  - At RESP it produces resp_err = 1 and resp_rdata = 0.
  - A misaligned write is suppressed, so the array is unchanged.
- DMEM_ALIGN_CHECK_EN undefined:
  - resp_err is tied to 0.
  - req_addr[1:0] is ignored; a misaligned access behaves as the aligned word access.

## Test plan
- Reset then idle, LATENCY=2: after reset, req_ready=1, resp_valid=0, busy=0 for 5 cycles with req_valid=0.
- Write then read, LATENCY=2: write 0xDEADBEEF to 0x10 accepted at T → resp_valid at T+2 with rdata 0, busy high T..T+1. Read 0x10 accepted at T+3 → resp_valid at T+5 with rdata 0xDEADBEEF.
- Back-to-back, LATENCY=1: req_valid held high with reads of 0x0, 0x4, 0x8 → acceptances every 2 cycles, one resp_valid pulse per request, req_ready low in each RESP cycle.
- Wrap, DEPTH_WORDS=64: write 0x12345678 to 0x104, then read 0x4 → rdata 0x12345678.
- Reset mid-access, LATENCY=3: write 0xAAAA5555 to 0x20 accepted at T, reset at T+1 → no resp_valid. A subsequent read of 0x20 returns the prior contents, not 0xAAAA5555.
- Misaligned, with DMEM_ALIGN_CHECK_EN: write 0x1 to 0x22 → resp_err=1 and word 8 unchanged. Without the macro → resp_err=0 and word 8 = 0x1.
